// File: rtl/knap_pkg.sv
// Shared definitions for the sequential knapsack evaluator: FSM state codes
// and a width-parametrised saturating adder.
package knap_pkg;

    typedef logic [1:0] knap_state_t;

    localparam knap_state_t ST_IDLE  = 2'd0;
    localparam knap_state_t ST_ACCUM = 2'd1;
    localparam knap_state_t ST_DONE  = 2'd2;

    // Unsigned add clamped to 2^w-1; both operands must already fit in w bits (w <= 31).
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        if (sum > lim) begin
            sat_add = lim[31:0];
        end else begin
            sat_add = sum[31:0];
        end
    endfunction

endpackage

// File: rtl/knap_coef_rf.sv
// Coefficient table: N_ITEMS rows of (N_DIMS+1) unsigned coefficients,
// dim 0 = value, dims 1..N_DIMS = costs. One write port, one row-read port.
module knap_coef_rf
    import knap_pkg::*;
#(
    parameter  int N_ITEMS = 20,
    parameter  int N_DIMS  = 2,
    parameter  int COEF_W  = 5,
    localparam int IW      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1,
    localparam int DW      = $clog2(N_DIMS + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we_i,
    input  logic [IW-1:0]                  item_i,
    input  logic [DW-1:0]                  dim_i,
    input  logic [COEF_W-1:0]              coef_i,
    input  logic [IW-1:0]                  rd_item_i,
    output logic [(N_DIMS+1)*COEF_W-1:0]   rd_row_o
);

    logic [COEF_W-1:0] mem_q [N_ITEMS][N_DIMS+1];
    logic              wr_ok_s;

    assign wr_ok_s = we_i && (32'(item_i) < 32'(N_ITEMS)) && (32'(dim_i) <= 32'(N_DIMS));

    // Table storage; reset clears every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                for (int d = 0; d <= N_DIMS; d++) begin
                    mem_q[i][d] <= '0;
                end
            end
        end else if (wr_ok_s) begin
            mem_q[item_i][dim_i] <= coef_i;
        end
    end

    // Combinational read of all dimensions of one item.
    always_comb begin
        rd_row_o = '0;
        for (int d = 0; d <= N_DIMS; d++) begin
            rd_row_o[d*COEF_W +: COEF_W] = mem_q[rd_item_i][d];
        end
    end

endmodule

// File: rtl/knap_eval_seq.sv
// Sequential knapsack candidate evaluator: one item per cycle, saturating sums.
// Optional macro KNAP_EARLY_EXIT_EN ends accumulation once any cost exceeds its bound.
module knap_eval_seq
    import knap_pkg::*;
#(
    parameter  int N_ITEMS = 20,
    parameter  int N_DIMS  = 2,
    parameter  int COEF_W  = 5,
    parameter  int SUM_W   = 9,
    localparam int IW      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1,
    localparam int DW      = $clog2(N_DIMS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [IW-1:0]             cfg_item,
    input  logic [DW-1:0]             cfg_dim,
    input  logic [COEF_W-1:0]         cfg_coef,
    input  logic [SUM_W-1:0]          min_value,
    input  logic [N_DIMS*SUM_W-1:0]   max_cost,
    input  logic                      sel_valid,
    output logic                      sel_ready,
    input  logic [N_ITEMS-1:0]        sel_vec,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_feasible,
    output logic [SUM_W-1:0]          res_value,
    output logic [N_DIMS-1:0]         res_cost_over,
    output logic                      res_value_low
);

    knap_state_t                    state_q, state_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [N_ITEMS-1:0]             sel_q, sel_d;
    logic [SUM_W-1:0]               min_q, min_d;
    logic [N_DIMS*SUM_W-1:0]        max_q, max_d;
    logic [SUM_W-1:0]               val_q, val_d;
    logic [N_DIMS-1:0][SUM_W-1:0]   cost_q, cost_d;
    logic                           sel_ready_q, sel_ready_d;
    logic                           res_valid_q, res_valid_d;
    logic                           res_feasible_q, res_feasible_d;
    logic [SUM_W-1:0]               res_value_q, res_value_d;
    logic [N_DIMS-1:0]              res_cost_over_q, res_cost_over_d;
    logic                           res_value_low_q, res_value_low_d;

    logic [(N_DIMS+1)*COEF_W-1:0]   row_s;
    logic [SUM_W-1:0]               add_val_s;
    logic [N_DIMS-1:0][SUM_W-1:0]   add_cost_s;
    logic [N_DIMS-1:0]              over_s;
    logic                           low_s;
    logic                           last_s;
    logic                           exit_s;
    logic                           rf_we_s;

    // Table writes are only honoured while no candidate is in flight.
    assign rf_we_s = cfg_we && (state_q == ST_IDLE);

    knap_coef_rf #(
        .N_ITEMS (N_ITEMS),
        .N_DIMS  (N_DIMS),
        .COEF_W  (COEF_W)
    ) u_coef_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (rf_we_s),
        .item_i    (cfg_item),
        .dim_i     (cfg_dim),
        .coef_i    (cfg_coef),
        .rd_item_i (idx_q),
        .rd_row_o  (row_s)
    );

    // Running sums including the current item, and their comparison against the bounds.
    always_comb begin
        add_val_s  = val_q;
        add_cost_s = cost_q;
        over_s     = '0;
        if (sel_q[idx_q]) begin
            add_val_s = SUM_W'(sat_add(32'(val_q), 32'(row_s[0 +: COEF_W]), SUM_W));
            for (int d = 0; d < N_DIMS; d++) begin
                add_cost_s[d] = SUM_W'(sat_add(32'(cost_q[d]),
                                               32'(row_s[(d+1)*COEF_W +: COEF_W]), SUM_W));
            end
        end else begin
            add_val_s  = val_q;
            add_cost_s = cost_q;
        end
        for (int d = 0; d < N_DIMS; d++) begin
            over_s[d] = add_cost_s[d] > max_q[d*SUM_W +: SUM_W];
        end
        low_s  = add_val_s < min_q;
        last_s = idx_q == IW'(N_ITEMS - 1);
`ifdef KNAP_EARLY_EXIT_EN
        exit_s = last_s || (|over_s);
`else
        exit_s = last_s;
`endif
    end

    // Control FSM and result capture.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        sel_d           = sel_q;
        min_d           = min_q;
        max_d           = max_q;
        val_d           = val_q;
        cost_d          = cost_q;
        sel_ready_d     = sel_ready_q;
        res_valid_d     = res_valid_q;
        res_feasible_d  = res_feasible_q;
        res_value_d     = res_value_q;
        res_cost_over_d = res_cost_over_q;
        res_value_low_d = res_value_low_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_d     = ST_ACCUM;
                    sel_d       = sel_vec;
                    min_d       = min_value;
                    max_d       = max_cost;
                    val_d       = '0;
                    cost_d      = '0;
                    idx_d       = '0;
                    sel_ready_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                val_d  = add_val_s;
                cost_d = add_cost_s;
                if (exit_s) begin
                    state_d         = ST_DONE;
                    res_valid_d     = 1'b1;
                    res_value_d     = add_val_s;
                    res_cost_over_d = over_s;
                    res_value_low_d = low_s;
                    res_feasible_d  = !low_s && !(|over_s);
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                    sel_ready_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                sel_ready_d = 1'b1;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            sel_q           <= '0;
            min_q           <= '0;
            max_q           <= '0;
            val_q           <= '0;
            cost_q          <= '0;
            sel_ready_q     <= 1'b1;
            res_valid_q     <= 1'b0;
            res_feasible_q  <= 1'b0;
            res_value_q     <= '0;
            res_cost_over_q <= '0;
            res_value_low_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            sel_q           <= sel_d;
            min_q           <= min_d;
            max_q           <= max_d;
            val_q           <= val_d;
            cost_q          <= cost_d;
            sel_ready_q     <= sel_ready_d;
            res_valid_q     <= res_valid_d;
            res_feasible_q  <= res_feasible_d;
            res_value_q     <= res_value_d;
            res_cost_over_q <= res_cost_over_d;
            res_value_low_q <= res_value_low_d;
        end
    end

    assign sel_ready     = sel_ready_q;
    assign res_valid     = res_valid_q;
    assign res_feasible  = res_feasible_q;
    assign res_value     = res_value_q;
    assign res_cost_over = res_cost_over_q;
    assign res_value_low = res_value_low_q;

endmodule

// File: tb/tb_knap_eval_seq.sv
// Testbench for knap_eval_seq: a 4-item instance for function/handshake tests
// and a 20-item instance for saturation, both against a behavioural model.
module tb_knap_eval_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    // 4-item instance
    logic        a_we;
    logic [1:0]  a_item;
    logic [1:0]  a_dim;
    logic [4:0]  a_coef;
    logic [8:0]  a_min;
    logic [17:0] a_max;
    logic        a_sv;
    logic        a_sr;
    logic [3:0]  a_vec;
    logic        a_rv;
    logic        a_rr;
    logic        a_feas;
    logic [8:0]  a_val;
    logic [1:0]  a_co;
    logic        a_low;

    // 20-item instance
    logic        b_we;
    logic [4:0]  b_item;
    logic [1:0]  b_dim;
    logic [4:0]  b_coef;
    logic [8:0]  b_min;
    logic [17:0] b_max;
    logic        b_sv;
    logic        b_sr;
    logic [19:0] b_vec;
    logic        b_rv;
    logic        b_rr;
    logic        b_feas;
    logic [8:0]  b_val;
    logic [1:0]  b_co;
    logic        b_low;

    knap_eval_seq #(.N_ITEMS(4), .N_DIMS(2), .COEF_W(5), .SUM_W(9)) dut4 (
        .clk(clk), .rst_n(rst_n), .cfg_we(a_we), .cfg_item(a_item), .cfg_dim(a_dim),
        .cfg_coef(a_coef), .min_value(a_min), .max_cost(a_max), .sel_valid(a_sv),
        .sel_ready(a_sr), .sel_vec(a_vec), .res_valid(a_rv), .res_ready(a_rr),
        .res_feasible(a_feas), .res_value(a_val), .res_cost_over(a_co), .res_value_low(a_low)
    );

    knap_eval_seq #(.N_ITEMS(20), .N_DIMS(2), .COEF_W(5), .SUM_W(9)) dut20 (
        .clk(clk), .rst_n(rst_n), .cfg_we(b_we), .cfg_item(b_item), .cfg_dim(b_dim),
        .cfg_coef(b_coef), .min_value(b_min), .max_cost(b_max), .sel_valid(b_sv),
        .sel_ready(b_sr), .sel_vec(b_vec), .res_valid(b_rv), .res_ready(b_rr),
        .res_feasible(b_feas), .res_value(b_val), .res_cost_over(b_co), .res_value_low(b_low)
    );

    // Reference coefficient table of the 4-item instance: [item][0=value,1=cost0,2=cost1]
    int coef4 [4][3];

    function automatic int sat9(input int x);
        return (x > 511) ? 511 : x;
    endfunction

    // Reference: sums of selected coefficients clamped at 511, verdict from the bounds.
    function automatic void model4(input logic [3:0] vec, input int minv, input int m0,
                                   input int m1, output int lat, output int val,
                                   output logic [1:0] co, output logic low, output logic feas);
        int c0;
        int c1;
        bit stop;
        val = 0; c0 = 0; c1 = 0; lat = 5; stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!stop) begin
                if (vec[i]) begin
                    val = sat9(val + coef4[i][0]);
                    c0  = sat9(c0 + coef4[i][1]);
                    c1  = sat9(c1 + coef4[i][2]);
                end
`ifdef KNAP_EARLY_EXIT_EN
                if ((c0 > m0 || c1 > m1) && i < 3) begin
                    stop = 1'b1;
                    lat  = i + 2;
                end
`endif
            end
        end
        co   = {(c1 > m1), (c0 > m0)};
        low  = val < minv;
        feas = !low && (co == 2'b00);
    endfunction

    task automatic a_write(input int item, input int dim, input int c);
        @(negedge clk);
        a_we = 1'b1; a_item = 2'(item); a_dim = 2'(dim); a_coef = 5'(c);
        @(negedge clk);
        a_we = 1'b0;
        if (dim <= 2) coef4[item][dim] = c;
    endtask

    task automatic a_start(input logic [3:0] vec, input int minv, input int m0, input int m1);
        @(negedge clk);
        a_vec = vec; a_min = 9'(minv); a_max = {9'(m1), 9'(m0)}; a_sv = 1'b1;
        @(negedge clk);
        a_sv = 1'b0;
        // bounds were snapshotted at the handshake; disturb the live inputs
        a_vec = 4'($urandom); a_min = 9'($urandom); a_max = 18'($urandom);
    endtask

    task automatic a_wait(input int start, output int lat);
        lat = start;
        while (a_rv !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic a_release();
        a_rr = 1'b1;
        @(negedge clk);
        a_rr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (a_sr !== 1'b1) begin errors++; $display("FAIL reset_sel_ready: got %b want 1", a_sr); end
        checks++; if (a_rv !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", a_rv); end
        checks++; if (a_feas !== 1'b0) begin errors++; $display("FAIL reset_feasible: got %b want 0", a_feas); end
        checks++; if (a_val !== 9'd0) begin errors++; $display("FAIL reset_value: got %0d want 0", a_val); end
        checks++; if (a_co !== 2'b00) begin errors++; $display("FAIL reset_cost_over: got %b want 00", a_co); end
        checks++; if (a_low !== 1'b0) begin errors++; $display("FAIL reset_value_low: got %b want 0", a_low); end
        checks++; if (b_sr !== 1'b1 || b_rv !== 1'b0) begin
            errors++; $display("FAIL reset_b_handshake: got sr=%b rv=%b want 1 0", b_sr, b_rv);
        end
    endtask

    task automatic test_directed();
        int lat;
        int vals [4]  = '{20, 18, 30, 29};
        int c0s  [4]  = '{18, 6, 5, 1};
        int c1s  [4]  = '{4, 4, 5, 28};
        for (int i = 0; i < 4; i++) begin
            a_write(i, 0, vals[i]);
            a_write(i, 1, c0s[i]);
            a_write(i, 2, c1s[i]);
        end
        a_start(4'b1111, 90, 60, 60);
        a_wait(1, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL dir_all_latency: got %0d want 5", lat); end
        checks++; if (a_val !== 9'd97) begin errors++; $display("FAIL dir_all_value: got %0d want 97", a_val); end
        checks++; if (a_feas !== 1'b1 || a_co !== 2'b00 || a_low !== 1'b0) begin
            errors++; $display("FAIL dir_all_verdict: got feas=%b co=%b low=%b want 1 00 0", a_feas, a_co, a_low);
        end
        a_release();
        a_start(4'b0111, 90, 60, 60);
        a_wait(1, lat);
        checks++; if (a_val !== 9'd68) begin errors++; $display("FAIL dir_0111_value: got %0d want 68", a_val); end
        checks++; if (a_feas !== 1'b0 || a_co !== 2'b00 || a_low !== 1'b1) begin
            errors++; $display("FAIL dir_0111_verdict: got feas=%b co=%b low=%b want 0 00 1", a_feas, a_co, a_low);
        end
        a_release();
        a_start(4'b1111, 90, 60, 40);
        a_wait(1, lat);
        checks++; if (a_feas !== 1'b0 || a_co !== 2'b10 || a_low !== 1'b0) begin
            errors++; $display("FAIL dir_cost1_verdict: got feas=%b co=%b low=%b want 0 10 0", a_feas, a_co, a_low);
        end
        a_release();
        a_start(4'b0000, 90, 60, 60);
        a_wait(1, lat);
        checks++; if (a_val !== 9'd0 || a_co !== 2'b00 || a_low !== 1'b1 || a_feas !== 1'b0) begin
            errors++; $display("FAIL dir_empty: got val=%0d co=%b low=%b feas=%b want 0 00 1 0", a_val, a_co, a_low, a_feas);
        end
        a_release();
    endtask

    task automatic test_early_exit();
        int lat;
        a_start(4'b1111, 0, 20, 60);
        a_wait(1, lat);
`ifdef KNAP_EARLY_EXIT_EN
        checks++; if (lat !== 3) begin errors++; $display("FAIL early_latency: got %0d want 3", lat); end
        checks++; if (a_val !== 9'd38) begin errors++; $display("FAIL early_value: got %0d want 38", a_val); end
`else
        checks++; if (lat !== 5) begin errors++; $display("FAIL early_latency: got %0d want 5", lat); end
        checks++; if (a_val !== 9'd97) begin errors++; $display("FAIL early_value: got %0d want 97", a_val); end
`endif
        checks++; if (a_co !== 2'b01 || a_feas !== 1'b0) begin
            errors++; $display("FAIL early_verdict: got co=%b feas=%b want 01 0", a_co, a_feas);
        end
        a_release();
    endtask

    task automatic test_backpressure();
        int lat;
        a_start(4'b1111, 90, 60, 60);
        a_wait(1, lat);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin a_sv = 1'b1; a_vec = 4'b0001; end
            checks++; if (a_rv !== 1'b1 || a_sr !== 1'b0) begin
                errors++; $display("FAIL bp_handshake c%0d: got rv=%b sr=%b want 1 0", k, a_rv, a_sr);
            end
            checks++; if (a_val !== 9'd97 || a_feas !== 1'b1 || a_co !== 2'b00) begin
                errors++; $display("FAIL bp_stable c%0d: got val=%0d feas=%b co=%b want 97 1 00", k, a_val, a_feas, a_co);
            end
            @(negedge clk);
        end
        a_sv = 1'b0;
        a_release();
        checks++; if (a_sr !== 1'b1 || a_rv !== 1'b0) begin
            errors++; $display("FAIL bp_turnaround: got sr=%b rv=%b want 1 0", a_sr, a_rv);
        end
    endtask

    task automatic test_cfg_gating();
        int lat, ev, el;
        logic [1:0] eco;
        logic elow, efeas;
        model4(4'b1111, 90, 60, 60, el, ev, eco, elow, efeas);
        for (int r = 0; r < 2; r++) begin
            a_start(4'b1111, 90, 60, 60);
            a_we = 1'b1; a_item = 2'd0; a_dim = 2'd0; a_coef = 5'd31;
            @(negedge clk);
            a_we = 1'b0;
            a_wait(2, lat);
            checks++; if (a_val !== 9'(ev) || a_feas !== efeas) begin
                errors++; $display("FAIL gate_run%0d: got val=%0d feas=%b want %0d %b", r, a_val, a_feas, ev, efeas);
            end
            a_release();
        end
    endtask

    task automatic test_random();
        int lat, ev, el, m0, m1, mn;
        logic [3:0] vec;
        logic [1:0] eco;
        logic elow, efeas;
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(2) == 0) begin
                a_write(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(31)));
            end
            vec = 4'($urandom);
            mn  = int'($urandom_range(150));
            m0  = ($urandom_range(4) == 0) ? 511 : int'($urandom_range(100));
            m1  = ($urandom_range(4) == 0) ? 511 : int'($urandom_range(100));
            model4(vec, mn, m0, m1, el, ev, eco, elow, efeas);
            a_start(vec, mn, m0, m1);
            a_wait(1, lat);
            checks++; if (lat !== el) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, el); end
            checks++; if (a_val !== 9'(ev) || a_co !== eco || a_low !== elow || a_feas !== efeas) begin
                errors++;
                $display("FAIL rnd%0d_result: got val=%0d co=%b low=%b feas=%b want %0d %b %b %b",
                         n, a_val, a_co, a_low, a_feas, ev, eco, elow, efeas);
            end
            a_release();
        end
    endtask

    task automatic test_saturation();
        int lat;
        int want_lat [2];
        int m0s [2] = '{511, 510};
        logic [1:0] want_co [2] = '{2'b00, 2'b01};
        want_lat[0] = 21;
`ifdef KNAP_EARLY_EXIT_EN
        want_lat[1] = 18;
`else
        want_lat[1] = 21;
`endif
        for (int i = 0; i < 20; i++) begin
            for (int d = 0; d < 3; d++) begin
                @(negedge clk);
                b_we = 1'b1; b_item = 5'(i); b_dim = 2'(d); b_coef = 5'd31;
            end
        end
        @(negedge clk);
        b_we = 1'b0;
        for (int r = 0; r < 2; r++) begin
            b_vec = 20'hFFFFF; b_min = 9'd0; b_max = {9'd511, 9'(m0s[r])}; b_sv = 1'b1;
            @(negedge clk);
            b_sv = 1'b0;
            lat = 1;
            while (b_rv !== 1'b1 && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            checks++; if (lat !== want_lat[r]) begin errors++; $display("FAIL sat%0d_latency: got %0d want %0d", r, lat, want_lat[r]); end
            checks++; if (b_val !== 9'd511) begin errors++; $display("FAIL sat%0d_value: got %0d want 511", r, b_val); end
            checks++; if (b_co !== want_co[r] || b_feas !== (want_co[r] == 2'b00)) begin
                errors++; $display("FAIL sat%0d_verdict: got co=%b feas=%b want %b", r, b_co, b_feas, want_co[r]);
            end
            b_rr = 1'b1;
            @(negedge clk);
            b_rr = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int lat, ev, el;
        logic [1:0] eco;
        logic elow, efeas;
        a_start(4'b1111, 90, 60, 60);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) for (int d = 0; d < 3; d++) coef4[i][d] = 0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (a_rv !== 1'b0 || a_sr !== 1'b1) begin
                errors++; $display("FAIL rstmid_idle c%0d: got rv=%b sr=%b want 0 1", k, a_rv, a_sr);
            end
            @(negedge clk);
        end
        for (int r = 0; r < 2; r++) begin
            model4(4'b1111, r, 0, 0, el, ev, eco, elow, efeas);
            a_start(4'b1111, r, 0, 0);
            a_wait(1, lat);
            checks++; if (a_val !== 9'(ev) || a_co !== eco || a_low !== elow || a_feas !== efeas) begin
                errors++;
                $display("FAIL rstmid_cleared%0d: got val=%0d co=%b low=%b feas=%b want %0d %b %b %b",
                         r, a_val, a_co, a_low, a_feas, ev, eco, elow, efeas);
            end
            a_release();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_we = 1'b0; a_item = 2'd0; a_dim = 2'd0; a_coef = 5'd0; a_min = 9'd0; a_max = 18'd0;
        a_sv = 1'b0; a_vec = 4'd0; a_rr = 1'b0;
        b_we = 1'b0; b_item = 5'd0; b_dim = 2'd0; b_coef = 5'd0; b_min = 9'd0; b_max = 18'd0;
        b_sv = 1'b0; b_vec = 20'd0; b_rr = 1'b0;
        for (int i = 0; i < 4; i++) for (int d = 0; d < 3; d++) coef4[i][d] = 0;
        test_reset();
        test_directed();
        test_early_exit();
        test_backpressure();
        test_cfg_gating();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
